micro_ucr_nonce_search: RTL and testbench
=========================================

# micro_ucr_nonce_search

Initiator for the micro_ucr hash core: it builds each 128-bit block from a fixed 96-bit payload and an incrementing 32-bit nonce. For each block it drives the core's active-low reset and `fill`, waits a fixed hash latency, and checks the returned 24-bit hash against a difficulty target. It sits between the host/test controller and one `micro_ucr_hash` instance. It reports the first nonce whose hash meets the target, or exhaustion of the nonce range.

## Interface
- `HASH_LAT`, default 34: cycles `hash_rst_L` is high (RUN state) before `H_in` is valid.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start` in 1: begin search; sampled only in IDLE.
- `payload` in 96: upper block bits; captured at start.
- `target` in 8: difficulty; captured at start.
- `max_nonce` in 32: last nonce tried (inclusive); captured at start.
- `abort` in 1: present only with `MICRO_UCR_ABORT_EN`.
- `H_in` in 24: hash from core.
- `bloque_out` out 128: `{payload, nonce}`, with nonce in [31:0].
- `fill` out 1: high during RUN.
- `hash_rst_L` out 1: core reset; low in IDLE, LOAD, CHECK, DONE.
- `busy` out 1: high in LOAD/RUN/CHECK/DONE.
- `done` out 1: one-cycle pulse, search ended.
- `found` out 1: result valid at done and held.
- `nonce` out 32: winning nonce, or last nonce tried.
- `hash` out 24: `H_in` from the last CHECK.

## Operation
- FSM states:
  - IDLE: `start` → LOAD; capture payload, target, max_nonce; nonce counter=0; clear found.
  - LOAD (1 cycle): drive `bloque_out`, `hash_rst_L`=0 → RUN; load down-counter with HASH_LAT-1.
  - RUN (HASH_LAT cycles): `hash_rst_L`=1, `fill`=1; counter reaches 0 → CHECK.
  - CHECK (1 cycle): register `hash`<=`H_in`, `nonce`<=counter.
    - Match → DONE with found=1.
    - Else if counter==max_nonce → DONE with found=0.
    - Else counter+1 → LOAD.
  - DONE (1 cycle): `done`=1 → IDLE.
- Match condition: `H_in[23:16] < target` AND `H_in[15:8] < target`, unsigned. target=0 never matches.
- No wrap: max_nonce=32'hFFFFFFFF ends after trying FFFFFFFF. The counter is never compared after overflow.
- `start` outside IDLE is ignored. Inputs changing mid-search have no effect.
- `found`/`nonce`/`hash` hold until the next accepted start. `found` clears at accept; nonce and hash hold their old values until the first CHECK.

## Timing
- Reset values: `bloque_out`=0, `fill`=0, `hash_rst_L`=0, `busy`=0, `done`=0, `found`=0, `nonce`=0, `hash`=0, state=IDLE, counters 0.
- Per attempt: HASH_LAT+2 cycles.
- Start accepted at edge t0; success at nonce n gives `done` high in cycle (n+1)(HASH_LAT+2)+1 after t0. Default HASH_LAT gives 37 for n=0.
- `hash_rst_L` low for at least 1 full cycle between attempts, with `bloque_out` stable from LOAD through RUN.
- Reset mid-search: immediate return to reset values, no done pulse.

## Configuration
- `MICRO_UCR_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in LOAD/RUN/CHECK → DONE next edge with found=0; `nonce`=counter, `hash` unchanged.
  - Abort in IDLE/DONE is ignored. Abort beats a same-cycle match.
- Undefined: no `abort` port; search runs to match or exhaustion.

## Structure
- Package `micro_ucr_pkg`:
  - state enum (IDLE, LOAD, RUN, CHECK, DONE);
  - `MICRO_UCR_HASH_LAT`=34;
  - block layout constants (PAYLOAD_W=96, NONCE_W=32, HASH_W=24).
- One sub-module, `micro_ucr_target_cmp`: combinational compare of H_in bytes against target, output `match`.

## Test plan
Bench uses a stub core returning a programmed H per nonce.
- Reset asserted mid-RUN at nonce 2 → all outputs 0 next sample. A new start with match at nonce 0 gives done at cycle 37.
- target=8'h10, stub H=24'h0F0F00 at nonce 3, other nonces 24'hFFFFFF → done at cycle 145, found=1, nonce=3, hash=24'h0F0F00.
- max_nonce=2, H always 24'hFFFFFF → done at cycle 109, found=0, nonce=2.
- target=0, H=24'h000000, max_nonce=0 → found=0 at cycle 37.
- start pulsed at cycle 10 of a search → ignored; exactly one done pulse.
- `MICRO_UCR_ABORT_EN`: abort in RUN of nonce 5 → done the next cycle, found=0, nonce=5, busy=0 the following cycle.

Source files
------------

// File: rtl/micro_ucr_pkg.sv
// micro_ucr_pkg: shared FSM state type and block/hash layout constants for the micro_ucr nonce search
package micro_ucr_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_e;
  localparam int MICRO_UCR_HASH_LAT = 34;
  localparam int PAYLOAD_W = 96;
  localparam int NONCE_W = 32;
  localparam int HASH_W = 24;
  localparam int TARGET_W = 8;
  localparam int BLOCK_W = PAYLOAD_W + NONCE_W;
endpackage

// File: rtl/micro_ucr_target_cmp.sv
// micro_ucr_target_cmp: difficulty check, both upper hash bytes strictly below target
module micro_ucr_target_cmp
  import micro_ucr_pkg::*;
(
  input  logic [15:0]         h_hi,
  input  logic [TARGET_W-1:0] target,
  output logic                match
);
  assign match = (h_hi[15:8] < target) && (h_hi[7:0] < target);
endmodule

// File: rtl/micro_ucr_nonce_search.sv
// micro_ucr_nonce_search: drives micro_ucr_hash over incrementing nonces until the target is met.
// Define MICRO_UCR_ABORT_EN to add the abort input.
module micro_ucr_nonce_search
  import micro_ucr_pkg::*;
#(
  parameter int HASH_LAT = MICRO_UCR_HASH_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [TARGET_W-1:0]  target,
  input  logic [NONCE_W-1:0]   max_nonce,
`ifdef MICRO_UCR_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [HASH_W-1:0]    H_in,
  output logic [BLOCK_W-1:0]   bloque_out,
  output logic                 fill,
  output logic                 hash_rst_L,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [NONCE_W-1:0]   nonce,
  output logic [HASH_W-1:0]    hash
);
  localparam int LAT_W = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;
  state_e state_q, state_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic [TARGET_W-1:0] tgt_q, tgt_d;
  logic [NONCE_W-1:0] max_q, max_d, cnt_q, cnt_d, nonce_q, nonce_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [BLOCK_W-1:0] bloque_q, bloque_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic run_q, run_d, busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic match, abort_w;
`ifdef MICRO_UCR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  micro_ucr_target_cmp u_cmp (
    .h_hi   (H_in[23:8]),
    .target (tgt_q),
    .match  (match)
  );
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    tgt_d   = tgt_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    nonce_d = nonce_q;
    hash_d  = hash_q;
    found_d = found_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        pay_d   = payload;
        tgt_d   = target;
        max_d   = max_nonce;
        cnt_d   = '0;
        found_d = 1'b0;
      end
      LOAD: begin
        state_d = abort_w ? DONE : RUN;
        lat_d   = LAT_W'(HASH_LAT - 1);
        nonce_d = abort_w ? cnt_q : nonce_q;
      end
      RUN: begin
        state_d = abort_w ? DONE : (lat_q == '0) ? CHECK : RUN;
        lat_d   = (lat_q == '0) ? lat_q : lat_q - 1'b1;
        nonce_d = abort_w ? cnt_q : nonce_q;
      end
      CHECK: begin
        nonce_d = cnt_q;
        hash_d  = abort_w ? hash_q : H_in;
        found_d = !abort_w && match;
        state_d = (abort_w || match || cnt_q == max_q) ? DONE : LOAD;
        cnt_d   = (state_d == LOAD) ? cnt_q + 1'b1 : cnt_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    run_d    = (state_d == RUN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    bloque_d = (state_d == LOAD) ? {pay_d, cnt_d} : bloque_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pay_q    <= '0;
      tgt_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      nonce_q  <= '0;
      hash_q   <= '0;
      found_q  <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bloque_q <= '0;
    end else begin
      state_q  <= state_d;
      pay_q    <= pay_d;
      tgt_q    <= tgt_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      nonce_q  <= nonce_d;
      hash_q   <= hash_d;
      found_q  <= found_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bloque_q <= bloque_d;
    end
  end
  assign bloque_out = bloque_q;
  assign fill       = run_q;
  assign hash_rst_L = run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign nonce      = nonce_q;
  assign hash       = hash_q;
endmodule

// File: tb/tb_micro_ucr_nonce_search.sv
// tb_micro_ucr_nonce_search: scoreboard bench with a stub hash core returning a programmed H per nonce
module tb_micro_ucr_nonce_search;
  localparam int L = 34;
  typedef struct {
    logic        found;
    logic [31:0] nonce;
    logic [23:0] hash;
    int          cyc;
    int          c0;
  } exp_t;
  logic clk = 1'b0;
  logic reset, start, abort;
  logic [95:0] payload;
  logic [7:0] target;
  logic [31:0] max_nonce;
  logic [23:0] H_in;
  logic [127:0] bloque_out;
  logic fill, hash_rst_L, busy, done, found;
  logic [31:0] nonce;
  logic [23:0] hash;
  logic win_en;
  logic [31:0] win_n;
  logic [23:0] win_h, oth_h;
  int cyc = 0, c0 = 0, n_done = 0, total = 0, bad = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign H_in = (win_en && bloque_out[31:0] == win_n) ? win_h : oth_h;
  micro_ucr_nonce_search dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .payload    (payload),
    .target     (target),
    .max_nonce  (max_nonce),
`ifdef MICRO_UCR_ABORT_EN
    .abort      (abort),
`endif
    .H_in       (H_in),
    .bloque_out (bloque_out),
    .fill       (fill),
    .hash_rst_L (hash_rst_L),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .nonce      (nonce),
    .hash       (hash)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] stub_h(input logic [31:0] n);
    return (win_en && n == win_n) ? win_h : oth_h;
  endfunction
  task automatic check_zero(input string tag);
    check({tag, "_bloque"}, bloque_out, 0);
    check({tag, "_fill"}, fill, 0);
    check({tag, "_rstl"}, hash_rst_L, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_nonce"}, nonce, 0);
    check({tag, "_hash"}, hash, 0);
  endtask
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("found", found, e.found);
        check("nonce", nonce, e.nonce);
        check("hash", hash, e.hash);
        check("cycle", cyc - e.c0 + 1, e.cyc);
      end
    end
  end
  task automatic launch(input logic [95:0] pl, input logic [7:0] tg, input logic [31:0] mx);
    exp_t e;
    logic [23:0] h;
    logic [31:0] pn;
    logic [23:0] ph;
    e.found = 1'b0;
    e.nonce = mx;
    e.hash = stub_h(mx);
    for (int n = 0; n <= int'(mx); n++) begin
      h = stub_h(n);
      if (h[23:16] < tg && h[15:8] < tg) begin
        e.found = 1'b1;
        e.nonce = n;
        e.hash = h;
        break;
      end
    end
    e.cyc = (int'(e.nonce) + 1) * (L + 2) + 1;
    @(negedge clk);
    pn = nonce;
    ph = hash;
    payload = pl;
    target = tg;
    max_nonce = mx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    e.c0 = c0;
    sb.push_back(e);
    check("load_busy", busy, 1);
    check("load_found_clr", found, 0);
    check("load_nonce_hold", nonce, pn);
    check("load_hash_hold", hash, ph);
    check("load_rstl", hash_rst_L, 0);
    check("load_bloque", bloque_out, {pl, 32'd0});
    @(negedge clk);
    check("run_rstl", hash_rst_L, 1);
    check("run_fill", fill, 1);
  endtask
  task automatic wait_done(input int want, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_done >= want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout_done", n_done, want);
  endtask
  task automatic wait_run_nonce(input logic [31:0] n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fill && bloque_out[31:0] == n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout_run_nonce", 0, n);
  endtask
  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    payload = '0;
    target = '0;
    max_nonce = '0;
    win_en = 1'b0;
    win_n = '0;
    win_h = '0;
    oth_h = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    // reset in the middle of RUN at nonce 2
    launch(96'hA5A5_0000_1111_2222_3333_4444, 8'h10, 32'd100);
    wait_run_nonce(32'd2, 300);
    nd = n_done;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_no_done", n_done, nd);
    // match at nonce 0
    win_en = 1'b1;
    win_n = 32'd0;
    win_h = 24'h0F0F00;
    launch(96'h1234_5678_9ABC_DEF0_1357_9BDF, 8'h10, 32'd50);
    wait_done(nd + 1, 200);
    // match at nonce 3
    win_n = 32'd3;
    launch(96'hDEAD_BEEF_0000_CAFE_F00D_0001, 8'h10, 32'd50);
    wait_done(nd + 2, 400);
    repeat (3) @(negedge clk);
    check("hold_found", found, 1);
    check("hold_nonce", nonce, 3);
    check("hold_hash", hash, 24'h0F0F00);
    check("hold_busy", busy, 0);
    check("hold_done", done, 0);
    // exhaustion at max_nonce 2
    win_en = 1'b0;
    oth_h = 24'hFFFFFF;
    launch(96'h0, 8'h10, 32'd2);
    wait_done(nd + 3, 400);
    // target 0 never matches
    oth_h = 24'h000000;
    launch(96'h5, 8'h00, 32'd0);
    wait_done(nd + 4, 200);
    // stray start and input changes mid-search
    win_en = 1'b1;
    win_n = 32'd1;
    win_h = 24'h050500;
    oth_h = 24'h202020;
    launch(96'hFEED_FACE_0BAD_F00D_1234_0000, 8'h10, 32'd50);
    repeat (8) @(negedge clk);
    start = 1'b1;
    target = 8'hFF;
    max_nonce = 32'd0;
    payload = 96'h0;
    @(negedge clk);
    start = 1'b0;
    check("payload_hold", bloque_out[127:32], 96'hFEED_FACE_0BAD_F00D_1234_0000);
    wait_done(nd + 5, 400);
    repeat (40) @(negedge clk);
    check("one_done", n_done - nd, 5);
`ifdef MICRO_UCR_ABORT_EN
    begin
      exp_t e;
      win_en = 1'b0;
      oth_h = 24'hFFFFFF;
      launch(96'h77, 8'h10, 32'd100);
      wait_run_nonce(32'd5, 400);
      sb.delete();
      e.found = 1'b0;
      e.nonce = 32'd5;
      e.hash = 24'hFFFFFF;
      e.cyc = cyc - c0 + 2;
      e.c0 = c0;
      sb.push_back(e);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort_done", done, 1);
      check("abort_ndone", n_done - nd, 6);
      @(negedge clk);
      check("abort_busy", busy, 0);
    end
`endif
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
